// File: rtl/priv_1_12_csr_rmw_unit.sv
// Zicsr read-modify-write initiator. Each CSR instruction runs as a fixed
// IDLE -> READ -> WRITE -> RESP sequence against the CSR file, with privilege,
// read-only and existence checks folded into the WRITE cycle.
module priv_1_12_csr_rmw_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_rs1_data,
  input  logic [4:0]        req_uimm,
  input  logic              req_rd_is_x0,
  input  logic [1:0]        cur_priv,
  input  logic              flush,
  output logic              csr_rd_en,
  output logic [ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_rd_data,
  input  logic              csr_rd_invalid,
  output logic              csr_wr_en,
  output logic [XLEN-1:0]   csr_wr_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state, nstate;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   opnd_q, old_q, rdata_q;
  logic [1:0]        priv_q;
  logic              uimm_nz_q, rdx0_q, inval_q, ill_q;

  logic accept, is_rw, no_read, do_write, illegal;

  assign accept   = req_valid & req_ready & ~flush;
  assign is_rw    = (f3_q[1:0] == 2'b01);
  // A write-only CSRRW(I) must not trigger read side effects.
  assign no_read  = is_rw & rdx0_q;
  // Set/clear forms only write when the rs1 field is nonzero, regardless of its value.
  assign do_write = is_rw | (uimm_nz_q & f3_q[1]);
  assign illegal  = (f3_q[1:0] == 2'b00)
                  | (addr_q[ADDR_W-3:ADDR_W-4] > priv_q)
                  | ((addr_q[ADDR_W-1:ADDR_W-2] == 2'b11) & do_write)
                  | inval_q;

  assign req_ready    = (state == IDLE);
  assign csr_rd_en    = (state == READ) & ~no_read;
  assign csr_wr_en    = (state == WRITE) & do_write & ~illegal;
  assign csr_addr     = addr_q;
  assign resp_valid   = (state == RESP);
  assign resp_rdata   = rdata_q;
  assign resp_illegal = ill_q;

  // Bitwise write data from the old value and the latched operand.
  always_comb begin
    csr_wr_data = '0;
    case (f3_q[1:0])
      2'b01:   csr_wr_data = opnd_q;
      2'b10:   csr_wr_data = old_q | opnd_q;
      2'b11:   csr_wr_data = old_q & ~opnd_q;
      default: csr_wr_data = '0;
    endcase
  end

  // Next-state: flush only cancels before the write is committed.
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (accept) nstate = READ;
      READ:  nstate = flush ? IDLE : WRITE;
      WRITE: nstate = RESP;
      RESP:  if (resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= nstate;
  end

  // Request capture, read sampling and response latching.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      f3_q      <= '0;
      addr_q    <= '0;
      opnd_q    <= '0;
      priv_q    <= '0;
      uimm_nz_q <= 1'b0;
      rdx0_q    <= 1'b0;
      old_q     <= '0;
      inval_q   <= 1'b0;
      rdata_q   <= '0;
      ill_q     <= 1'b0;
    end else begin
      if (accept) begin
        f3_q      <= req_funct3;
        addr_q    <= req_addr;
        opnd_q    <= req_funct3[2] ? {{(XLEN-5){1'b0}}, req_uimm} : req_rs1_data;
        priv_q    <= cur_priv;
        uimm_nz_q <= |req_uimm;
        rdx0_q    <= req_rd_is_x0;
      end
      if (state == READ) begin
        // Existence is checked every READ cycle, even when the strobe is suppressed.
        old_q   <= no_read ? '0 : csr_rd_data;
        inval_q <= csr_rd_invalid;
      end
      if (state == WRITE) begin
        rdata_q <= illegal ? '0 : old_q;
        ill_q   <= illegal;
      end
    end
  end

endmodule
